// File: rtl/dmac_sched_pkg.sv
// dmac_sched_pkg: shared types and width constants for the DMA channel scheduler.
//   sched_state_e : scheduler FSM state (IDLE / XFER / GAP)
//   STATE_W       : width of the state encoding
//   RR_CARRY_W    : extra bits needed when rotating a channel index by up to N
package dmac_sched_pkg;

  localparam int STATE_W    = 2;
  localparam int RR_CARRY_W = 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/dmac_sched_pick.sv
// dmac_sched_pick: combinational winner selection for the channel scheduler.
// Picks the eligible channel with the lowest priority value; ties go to the
// first such channel in round-robin order starting at (last_granted+1) mod N.
// Ports:
//   eligible     in  [N]              channels allowed to compete
//   ch_prior     in  [N*INDEX_WIDTH]  per-channel priority, lower wins
//   last_granted in  [INDEX_WIDTH]    most recently granted channel
//   win_valid    out                  at least one channel eligible
//   win_index    out [INDEX_WIDTH]    selected channel
module dmac_sched_pick
  import dmac_sched_pkg::*;
#(
  parameter int N           = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [N-1:0]             eligible,
  input  logic [N*INDEX_WIDTH-1:0] ch_prior,
  input  logic [INDEX_WIDTH-1:0]   last_granted,
  output logic                     win_valid,
  output logic [INDEX_WIDTH-1:0]   win_index
);

  localparam int SUM_W = INDEX_WIDTH + RR_CARRY_W;

  logic [INDEX_WIDTH-1:0] rot_idx_s [N];
  logic [INDEX_WIDTH-1:0] prio_s    [N];
  logic [INDEX_WIDTH-1:0] best_prior_s;

  // rot_idx_s[k] is the k-th channel visited in round-robin order. The sum
  // stays below 2N, so a single conditional subtract implements mod N.
  for (genvar k = 0; k < N; k++) begin : g_rot
    logic [SUM_W-1:0] sum_s;
    assign sum_s        = SUM_W'(last_granted) + SUM_W'(k + 1);
    assign rot_idx_s[k] = (sum_s >= SUM_W'(N)) ? INDEX_WIDTH'(sum_s - SUM_W'(N))
                                               : INDEX_WIDTH'(sum_s);
    assign prio_s[k]    = ch_prior[k*INDEX_WIDTH +: INDEX_WIDTH];
  end

  // Scan in rotation order; a strict "<" keeps the earliest candidate on a
  // priority tie, which is exactly the round-robin tie break.
  always_comb begin
    win_valid    = 1'b0;
    win_index    = '0;
    best_prior_s = '0;
    for (int k = 0; k < N; k++) begin
      if (eligible[rot_idx_s[k]] &&
          (!win_valid || (prio_s[rot_idx_s[k]] < best_prior_s))) begin
        win_valid    = 1'b1;
        win_index    = rot_idx_s[k];
        best_prior_s = prio_s[rot_idx_s[k]];
      end else begin
        best_prior_s = best_prior_s;
      end
    end
  end

endmodule

// File: rtl/dmac_chan_sched.sv
// dmac_chan_sched: DMA channel scheduler. Grants one channel at a time for a
// tenure of ch_len beats (0 means 2^BEAT_WIDTH), then spends one GAP cycle
// before returning to IDLE arbitration.
// Optional feature macro: DMAC_SCHED_LOCK_EN adds input ch_lock; a channel
// with lock and request high at a normal (non-abort) tenure end is re-granted
// straight from GAP without re-arbitration.
// Ports:
//   clk, rst (sync, active-high)
//   ch_req, ch_mask [N]; ch_prior [N*INDEX_WIDTH]; ch_len [N*BEAT_WIDTH]
//   ch_lock [N] (only with DMAC_SCHED_LOCK_EN)
//   beat_ack, abort                bus handshake for the granted channel
//   ch_grant [N], grant_index      registered one-hot grant / index
//   busy, beats_left, tenure_done  registered status
module dmac_chan_sched
  import dmac_sched_pkg::*;
#(
  parameter int N           = 4,
  parameter int INDEX_WIDTH = 2,
  parameter int BEAT_WIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             ch_req,
  input  logic [N*INDEX_WIDTH-1:0] ch_prior,
  input  logic [N-1:0]             ch_mask,
  input  logic [N*BEAT_WIDTH-1:0]  ch_len,
`ifdef DMAC_SCHED_LOCK_EN
  input  logic [N-1:0]             ch_lock,
`endif
  input  logic                     beat_ack,
  input  logic                     abort,
  output logic [N-1:0]             ch_grant,
  output logic [INDEX_WIDTH-1:0]   grant_index,
  output logic                     busy,
  output logic [BEAT_WIDTH:0]      beats_left,
  output logic                     tenure_done
);

  sched_state_e           state_r;
  logic [INDEX_WIDTH-1:0] last_granted_r;
  logic                   relock_r;
  logic [N-1:0]           eligible_s;
  logic                   win_valid_s;
  logic [INDEX_WIDTH-1:0] win_index_s;
  logic                   lock_hit_s;
  logic [BEAT_WIDTH-1:0]  len_s [N];

  function automatic logic [BEAT_WIDTH:0] decode_len(input logic [BEAT_WIDTH-1:0] len);
    if (len == '0) begin
      decode_len = {1'b1, {BEAT_WIDTH{1'b0}}};
    end else begin
      decode_len = {1'b0, len};
    end
  endfunction

  function automatic logic [N-1:0] onehot(input logic [INDEX_WIDTH-1:0] idx);
    onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  for (genvar c = 0; c < N; c++) begin : g_len
    assign len_s[c] = ch_len[c*BEAT_WIDTH +: BEAT_WIDTH];
  end

  assign eligible_s = ch_req & ~ch_mask;

  dmac_sched_pick #(
    .N           (N),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_pick (
    .eligible     (eligible_s),
    .ch_prior     (ch_prior),
    .last_granted (last_granted_r),
    .win_valid    (win_valid_s),
    .win_index    (win_index_s)
  );

`ifdef DMAC_SCHED_LOCK_EN
  assign lock_hit_s = ch_lock[grant_index] & ch_req[grant_index];
`else
  assign lock_hit_s = 1'b0;
`endif

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      ch_grant       <= '0;
      grant_index    <= '0;
      busy           <= 1'b0;
      beats_left     <= '0;
      tenure_done    <= 1'b0;
      relock_r       <= 1'b0;
      last_granted_r <= INDEX_WIDTH'(N - 1);
    end else begin
      case (state_r)
        IDLE: begin
          tenure_done <= 1'b0;
          if (win_valid_s) begin
            state_r        <= XFER;
            ch_grant       <= onehot(win_index_s);
            grant_index    <= win_index_s;
            busy           <= 1'b1;
            beats_left     <= decode_len(len_s[win_index_s]);
            last_granted_r <= win_index_s;
          end
        end
        XFER: begin
          // Abort wins over a simultaneous beat and leaves the count untouched.
          if (abort) begin
            state_r     <= GAP;
            ch_grant    <= '0;
            busy        <= 1'b0;
            tenure_done <= 1'b1;
            relock_r    <= 1'b0;
          end else if (beat_ack) begin
            if (beats_left == (BEAT_WIDTH+1)'(1)) begin
              state_r     <= GAP;
              ch_grant    <= '0;
              busy        <= 1'b0;
              beats_left  <= '0;
              tenure_done <= 1'b1;
              relock_r    <= lock_hit_s;
            end else begin
              beats_left <= beats_left - (BEAT_WIDTH+1)'(1);
            end
          end
        end
        GAP: begin
          tenure_done <= 1'b0;
          relock_r    <= 1'b0;
          // Locked re-grant keeps grant_index and last_granted as they are.
          if (relock_r) begin
            state_r    <= XFER;
            ch_grant   <= onehot(grant_index);
            busy       <= 1'b1;
            beats_left <= decode_len(len_s[grant_index]);
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          ch_grant    <= '0;
          busy        <= 1'b0;
          tenure_done <= 1'b0;
          relock_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_chan_sched.sv
// tb_dmac_chan_sched: self-checking bench for dmac_chan_sched (N=4, BEAT_WIDTH=5).
// Expected grant indices are queued when requests are driven and compared when
// the grant appears. Define DMAC_SCHED_LOCK_EN to also exercise the lock path.
module tb_dmac_chan_sched;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int BW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_req;
  logic [N*IW-1:0] ch_prior;
  logic [N-1:0]    ch_mask;
  logic [N*BW-1:0] ch_len;
`ifdef DMAC_SCHED_LOCK_EN
  logic [N-1:0]    ch_lock;
`endif
  logic            beat_ack;
  logic            abort;
  logic [N-1:0]    ch_grant;
  logic [IW-1:0]   grant_index;
  logic            busy;
  logic [BW:0]     beats_left;
  logic            tenure_done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  dmac_chan_sched #(.N(N), .INDEX_WIDTH(IW), .BEAT_WIDTH(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_req      (ch_req),
    .ch_prior    (ch_prior),
    .ch_mask     (ch_mask),
    .ch_len      (ch_len),
`ifdef DMAC_SCHED_LOCK_EN
    .ch_lock     (ch_lock),
`endif
    .beat_ack    (beat_ack),
    .abort       (abort),
    .ch_grant    (ch_grant),
    .grant_index (grant_index),
    .busy        (busy),
    .beats_left  (beats_left),
    .tenure_done (tenure_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_req = '0; ch_prior = '0; ch_mask = '0; ch_len = '0;
    beat_ack = 1'b0; abort = 1'b0;
`ifdef DMAC_SCHED_LOCK_EN
    ch_lock = '0;
`endif
    tick(); tick();
    checks++; if (ch_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", ch_grant); end
    checks++; if (grant_index !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", grant_index); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (beats_left !== 6'd0) begin errors++; $display("FAIL reset_beats: got %0d want 0", beats_left); end
    checks++; if (tenure_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tenure_done); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e;
    ch_prior = {2'd0, 2'd1, 2'd1, 2'd3};
    ch_len = '0; ch_len[1*BW +: BW] = 5'd3;
    ch_req = 4'b0110; exp_q.push_back(1);
    tick();
    e = exp_q.pop_front();
    checks++; if (grant_index !== IW'(e) || ch_grant !== 4'b0010) begin errors++; $display("FAIL basic_grant: got idx %0d grant %b want idx %0d grant 0010", grant_index, ch_grant, e); end
    checks++; if (beats_left !== 6'd3 || busy !== 1'b1) begin errors++; $display("FAIL basic_load: got beats %0d busy %b want 3 1", beats_left, busy); end
    // Inputs change mid-tenure; the tenure must be unaffected.
    ch_req = 4'b1001; ch_len[1*BW +: BW] = 5'd7; ch_prior = '0; beat_ack = 1'b1;
    tick();
    checks++; if (beats_left !== 6'd2 || ch_grant !== 4'b0010) begin errors++; $display("FAIL basic_ack1: got beats %0d grant %b want 2 0010", beats_left, ch_grant); end
    ch_req = '0;
    tick();
    checks++; if (beats_left !== 6'd1 || tenure_done !== 1'b0) begin errors++; $display("FAIL basic_ack2: got beats %0d done %b want 1 0", beats_left, tenure_done); end
    tick();
    checks++; if (tenure_done !== 1'b1 || ch_grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL basic_end: got done %b grant %b busy %b want 1 0000 0", tenure_done, ch_grant, busy); end
    beat_ack = 1'b0;
    tick();
    checks++; if (tenure_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", tenure_done); end
    checks++; if (grant_index !== 2'd1) begin errors++; $display("FAIL basic_index_hold: got %0d want 1", grant_index); end
  endtask

  task automatic test_round_robin();
    int e;
    int last_t;
    logic [N-1:0] prev_grant;
    logic [N-1:0] one;
    one = 4'b0001;
    rst = 1'b1; tick(); rst = 1'b0;
    ch_prior = {4{2'd2}}; ch_len = {4{5'd1}}; ch_req = 4'hF; beat_ack = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    prev_grant = '0; last_t = -1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      tick();
      if (ch_grant !== 4'b0000 && prev_grant === 4'b0000) begin
        e = exp_q.pop_front();
        checks++; if (grant_index !== IW'(e) || ch_grant !== (one << e)) begin errors++; $display("FAIL rr_order: got idx %0d grant %b want idx %0d", grant_index, ch_grant, e); end
        if (last_t >= 0) begin
          checks++; if (cyc - last_t != 3) begin errors++; $display("FAIL rr_spacing: got %0d cycles want 3", cyc - last_t); end
        end
        last_t = cyc;
      end
      prev_grant = ch_grant;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_timeout: %0d grants missing want 0", exp_q.size()); exp_q.delete(); end
    ch_req = '0;
    tick(); tick();
    beat_ack = 1'b0;
    tick();
  endtask

  task automatic test_len_zero();
    int e;
    ch_len = '0; ch_prior = '0; ch_req = 4'b0001; exp_q.push_back(0);
    tick();
    e = exp_q.pop_front();
    checks++; if (grant_index !== IW'(e) || beats_left !== 6'd32) begin errors++; $display("FAIL len0_load: got idx %0d beats %0d want idx %0d beats 32", grant_index, beats_left, e); end
    ch_req = '0; beat_ack = 1'b1;
    repeat (31) tick();
    checks++; if (beats_left !== 6'd1 || tenure_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL len0_31acks: got beats %0d done %b busy %b want 1 0 1", beats_left, tenure_done, busy); end
    tick();
    checks++; if (tenure_done !== 1'b1 || beats_left !== 6'd0) begin errors++; $display("FAIL len0_end: got done %b beats %0d want 1 0", tenure_done, beats_left); end
    beat_ack = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int e;
    ch_len = '0; ch_len[3*BW +: BW] = 5'd5; ch_req = 4'b1000; exp_q.push_back(3);
    tick();
    e = exp_q.pop_front();
    checks++; if (grant_index !== IW'(e) || beats_left !== 6'd5) begin errors++; $display("FAIL abort_grant: got idx %0d beats %0d want idx %0d beats 5", grant_index, beats_left, e); end
    ch_req = '0; abort = 1'b1; beat_ack = 1'b1;
    tick();
    checks++; if (tenure_done !== 1'b1 || busy !== 1'b0 || ch_grant !== 4'b0000) begin errors++; $display("FAIL abort_end: got done %b busy %b grant %b want 1 0 0000", tenure_done, busy, ch_grant); end
    checks++; if (beats_left !== 6'd5) begin errors++; $display("FAIL abort_nodec: got beats %0d want 5", beats_left); end
    // Still asserted in GAP and then IDLE: must be ignored.
    tick();
    checks++; if (tenure_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_gap_ignore: got done %b busy %b want 0 0", tenure_done, busy); end
    tick();
    checks++; if (tenure_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle_ignore: got done %b busy %b want 0 0", tenure_done, busy); end
    abort = 1'b0; beat_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int e;
    ch_len = '0; ch_len[2*BW +: BW] = 5'd6; ch_req = 4'b0100; exp_q.push_back(2);
    tick();
    e = exp_q.pop_front();
    checks++; if (grant_index !== IW'(e)) begin errors++; $display("FAIL rstmid_grant: got idx %0d want %0d", grant_index, e); end
    ch_req = '0; beat_ack = 1'b1;
    tick(); tick();
    beat_ack = 1'b0;
    checks++; if (beats_left !== 6'd4) begin errors++; $display("FAIL rstmid_beats: got %0d want 4", beats_left); end
    ch_req = 4'hF; ch_prior = {4{2'd1}}; ch_len = {4{5'd1}}; rst = 1'b1;
    tick();
    checks++; if ({ch_grant, grant_index, busy, beats_left, tenure_done} !== 14'd0) begin errors++; $display("FAIL rstmid_zero: got grant %b idx %0d busy %b beats %0d done %b want all 0", ch_grant, grant_index, busy, beats_left, tenure_done); end
    rst = 1'b0; exp_q.push_back(0);
    tick();
    e = exp_q.pop_front();
    checks++; if (grant_index !== IW'(e) || ch_grant !== 4'b0001 || tenure_done !== 1'b0) begin errors++; $display("FAIL rstmid_tie: got idx %0d grant %b done %b want idx %0d 0001 0", grant_index, ch_grant, tenure_done, e); end
    ch_req = '0; beat_ack = 1'b1;
    tick(); tick();
    beat_ack = 1'b0;
  endtask

`ifdef DMAC_SCHED_LOCK_EN
  task automatic test_lock();
    int e;
    rst = 1'b1; tick(); rst = 1'b0;
    ch_prior = {2'd3, 2'd1, 2'd0, 2'd3}; ch_len = {4{5'd1}};
    ch_lock = 4'b0100; ch_req = 4'b0100; exp_q.push_back(2);
    tick();
    e = exp_q.pop_front();
    checks++; if (grant_index !== IW'(e) || ch_grant !== 4'b0100) begin errors++; $display("FAIL lock_first: got idx %0d grant %b want idx %0d", grant_index, ch_grant, e); end
    ch_req = 4'b0110; beat_ack = 1'b1;
    tick();
    checks++; if (tenure_done !== 1'b1 || ch_grant !== 4'b0000) begin errors++; $display("FAIL lock_gap: got done %b grant %b want 1 0000", tenure_done, ch_grant); end
    exp_q.push_back(2);
    beat_ack = 1'b0;
    tick();
    e = exp_q.pop_front();
    checks++; if (grant_index !== IW'(e) || ch_grant !== 4'b0100 || beats_left !== 6'd1) begin errors++; $display("FAIL lock_regrant: got idx %0d grant %b beats %0d want idx %0d 0100 1", grant_index, ch_grant, beats_left, e); end
    ch_lock = '0; beat_ack = 1'b1;
    tick();
    beat_ack = 1'b0; exp_q.push_back(1);
    tick(); tick();
    e = exp_q.pop_front();
    checks++; if (grant_index !== IW'(e) || ch_grant !== 4'b0010) begin errors++; $display("FAIL lock_release: got idx %0d grant %b want idx %0d", grant_index, ch_grant, e); end
    ch_req = '0; beat_ack = 1'b1;
    tick(); tick();
    beat_ack = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_len_zero();
    test_abort();
    test_reset_mid();
`ifdef DMAC_SCHED_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
